// File: rtl/cl_afu_pkg.sv
// Shared constants and FSM state type for the CL pre-AFU buffer unpacker.
package cl_afu_pkg;

  localparam int CL        = 512;
  localparam int CL_HEAD   = 16;
  localparam int ST_W      = 62;
  localparam int ST_PER_CL = 8;
  localparam int LANE_W    = $clog2(ST_PER_CL);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EMIT,
    DONE
  } unpack_state_t;

endpackage

// File: rtl/cl_unpack_afu.sv
// Reads one AFU frame from the CL buffer and streams its payload as 62-bit ST words.
// Optional completed-frame counter port frm_cnt is enabled by defining CL_UNPACK_CNT_EN.
module cl_unpack_afu
  import cl_afu_pkg::*;
#(
  parameter int w_NumOfST_in_AFUFrm = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ff_rd_ready,
  output logic                           ff_rdreq,
  input  logic [CL-1:0]                  ff_q,
  output logic                           ff_rd_finish,
  input  logic [w_NumOfST_in_AFUFrm-1:0] sb_len,
  output logic [ST_W-1:0]                source_data,
  output logic                           source_valid,
  input  logic                           source_ready,
  output logic                           source_sop,
  output logic                           source_eop,
  output logic [CL_HEAD-1:0]             source_head
`ifdef CL_UNPACK_CNT_EN
  ,
  output logic [31:0]                    frm_cnt
`endif
);

  localparam int PAY_W = CL - CL_HEAD;

  unpack_state_t                  r_state;
  unpack_state_t                  w_next;
  logic [w_NumOfST_in_AFUFrm-1:0] r_len;
  logic [w_NumOfST_in_AFUFrm-1:0] r_stCnt;
  logic [LANE_W-1:0]              r_lane;
  logic [LANE_W-1:0]              w_laneNext;
  logic [PAY_W-1:0]               r_payload;
  logic [PAY_W-1:0]               w_paySrc;
  logic                           w_xfer;
  logic                           w_lastSt;
  logic                           w_accept;

  assign w_xfer   = (r_state == EMIT) && source_ready;
  assign w_lastSt = ((r_stCnt + 1'b1) == r_len);
  assign w_accept = (r_state == IDLE) && ff_rd_ready && (sb_len != '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (ff_rd_ready) begin
          w_next = (sb_len != '0) ? FETCH : DONE;
        end
      end
      FETCH: w_next = LOAD;
      LOAD:  w_next = EMIT;
      EMIT: begin
        if (w_xfer) begin
          if (w_lastSt) begin
            w_next = DONE;
          end else if (r_lane == LANE_W'(ST_PER_CL - 1)) begin
            w_next = FETCH;
          end
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The word for the next lane is preloaded so source_data stays a plain register.
  assign w_laneNext = (r_state == LOAD) ? '0 : r_lane + 1'b1;
  assign w_paySrc   = (r_state == LOAD) ? ff_q[PAY_W-1:0] : r_payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_rdreq     <= 1'b0;
      ff_rd_finish <= 1'b0;
      source_valid <= 1'b0;
      source_data  <= '0;
      source_head  <= '0;
      r_len        <= '0;
      r_stCnt      <= '0;
      r_lane       <= '0;
      r_payload    <= '0;
    end else begin
      ff_rdreq     <= (w_next == FETCH);
      ff_rd_finish <= (w_next == DONE);
      source_valid <= (w_next == EMIT);
      if (w_accept) begin
        r_len   <= sb_len;
        r_stCnt <= '0;
      end
      if (r_state == LOAD) begin
        r_payload   <= ff_q[PAY_W-1:0];
        source_head <= ff_q[CL-1:PAY_W];
        r_lane      <= '0;
      end
      if (w_xfer) begin
        r_stCnt <= r_stCnt + 1'b1;
        r_lane  <= r_lane + 1'b1;
      end
      if ((r_state == LOAD) || w_xfer) begin
        source_data <= w_paySrc[int'(w_laneNext) * ST_W +: ST_W];
      end
    end
  end

  assign source_sop = (r_state == EMIT) && (r_stCnt == '0);
  assign source_eop = (r_state == EMIT) && (r_stCnt == (r_len - 1'b1));

`ifdef CL_UNPACK_CNT_EN
  logic [31:0] r_frmCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frmCnt <= '0;
    end else if (r_state == DONE) begin
      r_frmCnt <= r_frmCnt + 32'd1;
    end
  end

  assign frm_cnt = r_frmCnt;
`endif

endmodule

// File: tb/tb_cl_unpack_afu.sv
// Self-checking bench for cl_unpack_afu: table of frame lengths plus reset and counter sequences.
// Frame-counter checks are compiled in when CL_UNPACK_CNT_EN is defined.
module tb_cl_unpack_afu;
  import cl_afu_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ff_rd_ready = 1'b0;
  logic              ff_rdreq;
  logic [CL-1:0]     ff_q = '0;
  logic              ff_rd_finish;
  logic [15:0]       sb_len = '0;
  logic [ST_W-1:0]   source_data;
  logic              source_valid;
  logic              source_ready = 1'b0;
  logic              source_sop;
  logic              source_eop;
  logic [CL_HEAD-1:0] source_head;
`ifdef CL_UNPACK_CNT_EN
  logic [31:0]       frm_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int rdreqCnt = 0;
  int finishCnt = 0;
  int finishCyc = 0;
  int validCyc = 0;
  int beatTotal = 0;
  int rdBase = 0;
  int beatBase = 0;
  int finBase = 0;
  int validBase = 0;
  int startCyc = 0;
  bit randMode = 1'b0;

  logic [ST_W-1:0]    beatData [256];
  logic               beatSop  [256];
  logic               beatEop  [256];
  logic [CL_HEAD-1:0] beatHead [256];
  int                 beatCyc  [256];

  bit                 prevStall = 1'b0;
  logic [ST_W-1:0]    prevData = '0;
  logic               prevSop = 1'b0;
  logic               prevEop = 1'b0;
  logic [CL_HEAD-1:0] prevHead = '0;

  typedef struct {
    int len;
    bit rnd;
    int expBeats;
    int expReads;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  cl_unpack_afu #(.w_NumOfST_in_AFUFrm(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .ff_rd_ready  (ff_rd_ready),
    .ff_rdreq     (ff_rdreq),
    .ff_q         (ff_q),
    .ff_rd_finish (ff_rd_finish),
    .sb_len       (sb_len),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_head  (source_head)
`ifdef CL_UNPACK_CNT_EN
    ,
    .frm_cnt      (frm_cnt)
`endif
  );

  function automatic logic [ST_W-1:0] mkSt(input int c, input int l);
    return {6'h2A, 8'(c + 1), 8'(l + 1), 40'(32'hDEAD_0000 + c * 97 + l * 13)};
  endfunction

  function automatic logic [CL_HEAD-1:0] mkHead(input int c);
    return 16'(32'hC000 + c);
  endfunction

  function automatic logic [CL-1:0] mkCl(input int c);
    logic [CL-1:0] v;
    v = '0;
    for (int l = 0; l < ST_PER_CL; l++) begin
      v[l*ST_W +: ST_W] = mkSt(c, l);
    end
    v[CL-1 -: CL_HEAD] = mkHead(c);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Buffer model: the CL addressed by the read count of the current frame appears a cycle after rdreq.
  always @(posedge clk) begin
    if (ff_rdreq) begin
      ff_q <= mkCl(rdreqCnt - rdBase - 1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      source_ready = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cycle++;
    if (ff_rdreq) rdreqCnt++;
    if (ff_rd_finish) begin
      finishCnt++;
      finishCyc = cycle;
    end
    if (source_valid) validCyc++;
    if (prevStall && !rst) begin
      checkOutput("stall_valid", 64'(source_valid), 64'd1);
      checkOutput("stall_data", 64'(source_data), 64'(prevData));
      checkOutput("stall_sop", 64'(source_sop), 64'(prevSop));
      checkOutput("stall_eop", 64'(source_eop), 64'(prevEop));
      checkOutput("stall_head", 64'(source_head), 64'(prevHead));
    end
    if (source_valid && source_ready && beatTotal < 256) begin
      beatData[beatTotal] = source_data;
      beatSop[beatTotal]  = source_sop;
      beatEop[beatTotal]  = source_eop;
      beatHead[beatTotal] = source_head;
      beatCyc[beatTotal]  = cycle;
      beatTotal++;
    end
    prevStall = source_valid && !source_ready && !rst;
    prevData  = source_data;
    prevSop   = source_sop;
    prevEop   = source_eop;
    prevHead  = source_head;
  end

  task automatic startFrame(input int len, input bit rnd);
    randMode = rnd;
    @(posedge clk);
    #1;
    rdBase      = rdreqCnt;
    beatBase    = beatTotal;
    finBase     = finishCnt;
    validBase   = validCyc;
    startCyc    = cycle;
    ff_rd_ready = 1'b1;
    sb_len      = 16'(len);
    @(posedge clk);
    #1;
    ff_rd_ready = 1'b0;
    sb_len      = 16'hFFFF;
  endtask

  task automatic applyStimulus(input int len, input bit rnd);
    startFrame(len, rnd);
    for (int i = 0; i < 400 && finishCnt == finBase; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("finish_pulses", 64'(finishCnt - finBase), 64'd1);
  endtask

  task automatic checkFrame(input int len, input bit rnd, input int expBeats, input int expReads);
    int got;
    got = beatTotal - beatBase;
    checkOutput("beats", 64'(got), 64'(expBeats));
    checkOutput("reads", 64'(rdreqCnt - rdBase), 64'(expReads));
    for (int b = 0; b < expBeats && b < got && beatBase + b < 256; b++) begin
      checkOutput($sformatf("data_b%0d", b), 64'(beatData[beatBase+b]), 64'(mkSt(b / 8, b % 8)));
      checkOutput($sformatf("head_b%0d", b), 64'(beatHead[beatBase+b]), 64'(mkHead(b / 8)));
      checkOutput($sformatf("sop_b%0d", b), 64'(beatSop[beatBase+b]), 64'(b == 0));
      checkOutput($sformatf("eop_b%0d", b), 64'(beatEop[beatBase+b]), 64'(b == len - 1));
    end
    if (expBeats > 0 && got >= expBeats && beatBase + expBeats - 1 < 256) begin
      checkOutput("finish_lat", 64'(finishCyc - beatCyc[beatBase+expBeats-1]), 64'd1);
      if (!rnd) begin
        checkOutput("first_valid_lat", 64'(beatCyc[beatBase] - startCyc), 64'd4);
      end
    end
    if (expBeats == 0) begin
      checkOutput("no_valid", 64'(validCyc - validBase), 64'd0);
      checkOutput("finish_at", 64'(finishCyc - startCyc), 64'd2);
    end
  endtask

  initial begin
    vecs[0] = '{len: 16, rnd: 1'b0, expBeats: 16, expReads: 2};
    vecs[1] = '{len: 11, rnd: 1'b0, expBeats: 11, expReads: 2};
    vecs[2] = '{len: 1,  rnd: 1'b0, expBeats: 1,  expReads: 1};
    vecs[3] = '{len: 0,  rnd: 1'b0, expBeats: 0,  expReads: 0};
    vecs[4] = '{len: 8,  rnd: 1'b1, expBeats: 8,  expReads: 1};
    vecs[5] = '{len: 9,  rnd: 1'b0, expBeats: 9,  expReads: 2};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rdreq", 64'(ff_rdreq), 64'd0);
    checkOutput("rst_finish", 64'(ff_rd_finish), 64'd0);
    checkOutput("rst_valid", 64'(source_valid), 64'd0);
    checkOutput("rst_sop", 64'(source_sop), 64'd0);
    checkOutput("rst_eop", 64'(source_eop), 64'd0);
    checkOutput("rst_data", 64'(source_data), 64'd0);
    checkOutput("rst_head", 64'(source_head), 64'd0);
`ifdef CL_UNPACK_CNT_EN
    checkOutput("rst_frm_cnt", 64'(frm_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      $display("[TB] frame len=%0d rnd=%0d", vecs[v].len, vecs[v].rnd);
      applyStimulus(vecs[v].len, vecs[v].rnd);
      checkFrame(vecs[v].len, vecs[v].rnd, vecs[v].expBeats, vecs[v].expReads);
    end

    // Reset in the middle of emitting a 24-ST frame.
    begin
      int finBefore;
      startFrame(24, 1'b0);
      for (int i = 0; i < 200 && (beatTotal - beatBase) < 5; i++) @(negedge clk);
      checkOutput("midframe_reached", 64'((beatTotal - beatBase) >= 5), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_rdreq", 64'(ff_rdreq), 64'd0);
      checkOutput("arst_finish", 64'(ff_rd_finish), 64'd0);
      checkOutput("arst_valid", 64'(source_valid), 64'd0);
      checkOutput("arst_sop", 64'(source_sop), 64'd0);
      checkOutput("arst_eop", 64'(source_eop), 64'd0);
      checkOutput("arst_data", 64'(source_data), 64'd0);
      checkOutput("arst_head", 64'(source_head), 64'd0);
      checkOutput("arst_state", 64'(dut.r_state), 64'(IDLE));
      finBefore = finishCnt;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("arst_no_finish", 64'(finishCnt - finBefore), 64'd0);
`ifdef CL_UNPACK_CNT_EN
      checkOutput("arst_frm_cnt", 64'(frm_cnt), 64'd0);
`endif
    end

    applyStimulus(3, 1'b0);
    checkFrame(3, 1'b0, 3, 1);
    applyStimulus(0, 1'b0);
    checkFrame(0, 1'b0, 0, 0);
    applyStimulus(2, 1'b0);
    checkFrame(2, 1'b0, 2, 1);
`ifdef CL_UNPACK_CNT_EN
    checkOutput("frm_cnt_3", 64'(frm_cnt), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cl_unpack_afu.md
# cl_unpack_afu

Frame unpacker directly downstream of the CL pre-AFU buffer. It waits for the buffer to hold a complete AFU frame, then reads it one cache line (CL) at a time. It strips the 16-bit CL head and emits the 496-bit payload to the AFU as a valid/ready stream of 62-bit symbol-time (ST) words with sop/eop framing. When the frame is fully emitted it pulses `ff_rd_finish` so the buffer can release the next frame.

## Interface
Parameters:
- `CL` = 512: cache-line width.
- `CL_HEAD` = 16: head field width, CL bits [511:496].
- `ST_W` = 62: ST word width.
- `ST_PER_CL` = 8: STs per CL payload; `ST_PER_CL*ST_W` must equal `CL-CL_HEAD`.
- `w_NumOfST_in_AFUFrm` = 16: width of the frame length in STs.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ff_rd_ready` in 1: the buffer holds one complete frame.
- `ff_rdreq` out 1: buffer read request; `ff_q` is valid one cycle later.
- `ff_q` in `CL`: buffer read data.
- `ff_rd_finish` out 1: one-cycle pulse when the frame is fully consumed.
- `sb_len` in `w_NumOfST_in_AFUFrm`: frame length in STs; sampled only when a frame is accepted.
- `source_data` out `ST_W`: ST word.
- `source_valid` out 1: `source_data` is valid.
- `source_ready` in 1: AFU accepts the word.
- `source_sop` out 1: first ST of the frame.
- `source_eop` out 1: last ST of the frame.
- `source_head` out `CL_HEAD`: head of the CL currently being emitted.
- `frm_cnt` out 32: completed-frame count. Present only with `CL_UNPACK_CNT_EN`.

## Operation
- FSM states: IDLE, FETCH, LOAD, EMIT, DONE. Reset state is IDLE.
- IDLE:
  - If `ff_rd_ready`=1 and `sb_len`≠0: latch `sb_len` into `len_r`, clear `st_cnt`, go to FETCH.
  - If `ff_rd_ready`=1 and `sb_len`=0: go to DONE without reading.
- FETCH: assert `ff_rdreq` for exactly one cycle, then go to LOAD.
- LOAD:
  - Capture `ff_q[CL-CL_HEAD-1:0]` into the payload register and `ff_q[CL-1:CL-CL_HEAD]` into `source_head`.
  - Clear `lane`, go to EMIT.
- EMIT:
  - `source_valid`=1 and `source_data`=payload[`lane*ST_W` +: `ST_W`].
  - ST0 is CL bits [61:0]; ST7 is CL bits [495:434].
  - On each transfer (valid & ready): increment `st_cnt` and `lane`.
  - After the transfer where `st_cnt+1`=`len_r`: go to DONE. The remaining lanes of a partial last CL are discarded.
  - Otherwise, after the transfer at `lane`=`ST_PER_CL-1`: go to FETCH.
- DONE: pulse `ff_rd_finish` for one cycle, then return to IDLE. `ff_rd_ready` is ignored in DONE.
- `source_sop` = EMIT & `st_cnt`=0.
- `source_eop` = EMIT & `st_cnt`=`len_r`-1.
- Arithmetic: `st_cnt` is `w_NumOfST_in_AFUFrm` bits and unsigned; `lane` is `$clog2(ST_PER_CL)` bits. `len_r`=1 gives a single-beat frame with sop=eop=1.
- While `source_ready`=0, `source_data`, `source_sop`, `source_eop` and `source_head` hold stable and `source_valid` stays 1.
- Changes to `sb_len` after acceptance have no effect on the current frame.

## Timing
- Reset values: `ff_rdreq`, `ff_rd_finish`, `source_valid`, `source_sop`, `source_eop` = 0. `source_data`, `source_head` = 0. `frm_cnt` = 0.
- Reset mid-frame returns the FSM to IDLE immediately. No `ff_rd_finish` is issued; the buffer is reset by the same system reset.
- Latency: `ff_rd_ready` seen in IDLE at cycle t gives `ff_rdreq` at t+1, load at t+2, and first `source_valid` at t+3.
- Per CL: 2 bubble cycles (FETCH, LOAD) followed by up to 8 transfer cycles.
- `ff_rd_finish` is asserted one cycle after the eop transfer. The earliest next acceptance is in the following IDLE cycle.
- All outputs are registered, except the sop/eop decode, which comes from registered state only.

## Configuration
- `CL_UNPACK_CNT_EN` defined:
  - The `frm_cnt` port exists and increments by 1 in every DONE cycle.
  - It wraps from 0xFFFFFFFF to 0.
  - Frames with `sb_len`=0 also count.
- `CL_UNPACK_CNT_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `cl_afu_pkg`:
  - Constants `CL`, `CL_HEAD`, `ST_W`, `ST_PER_CL`.
  - FSM state enum `unpack_state_t`.
- No sub-module. The CL-to-ST lane mux stays inline in the top module.

## Test plan
- Frame with `sb_len`=16 (2 CLs), `source_ready`=1:
  - 16 transfers, sop on beat 0, eop on beat 15.
  - Exactly 2 `ff_rdreq` pulses; `ff_rd_finish` 1 cycle after eop.
  - Data lanes match CL bits [62k+61:62k].
- Frame with `sb_len`=11:
  - Reads 2 CLs and emits 11 STs; eop is on lane 2 of CL1.
  - Lanes 3–7 of CL1 are never output.
- Frame with `sb_len`=1: one transfer with sop=eop=1, then `ff_rd_finish`.
- Frame with `sb_len`=0: no `ff_rdreq`, no `source_valid`, one `ff_rd_finish` pulse 2 cycles after `ff_rd_ready`.
- Frame with `sb_len`=8 and random `source_ready` (50%):
  - No word is lost or duplicated.
  - Outputs stay stable while `source_ready`=0.
- `rst` asserted mid-EMIT of a 24-ST frame:
  - All outputs are 0 asynchronously; the FSM is in IDLE.
  - A new frame afterwards starts with sop at `st_cnt`=0.
  - With `CL_UNPACK_CNT_EN`, `frm_cnt` is 0 after reset and 3 after three frames.
